// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling from a clk divider, mid-bit start validation,
// LSB-first data capture, stop-bit check with valid / frame_err strobes.
module uart_rx #(
  parameter int baudrate = 9600,
  parameter int sysclk   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = sysclk / (baudrate * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    tcnt, tcnt_next;
  logic [2:0]    bitcnt, bitcnt_next;
  logic [7:0]    shreg, shreg_next;
  logic [7:0]    data_next;
  logic          valid_next, ferr_next;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Holding the divider at zero in IDLE aligns the ticks to the detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (state != S_IDLE) && (div_cnt == DIV_MAX);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= 4'd0;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      tcnt      <= tcnt_next;
      bitcnt    <= bitcnt_next;
      shreg     <= shreg_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= ferr_next;
    end
  end

  always_comb begin
    state_next  = state;
    tcnt_next   = tcnt;
    bitcnt_next = bitcnt;
    shreg_next  = shreg;
    data_next   = data;
    valid_next  = 1'b0;
    ferr_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          tcnt_next  = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt == 4'd7) begin
            tcnt_next   = 4'd0;
            bitcnt_next = 3'd0;
            state_next  = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt == 4'd15) begin
            tcnt_next  = 4'd0;
            shreg_next = {rx_s, shreg[7:1]};
            if (bitcnt == 3'd7) begin
              state_next = S_STOP;
            end else begin
              bitcnt_next = bitcnt + 3'd1;
            end
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tcnt == 4'd15) begin
            tcnt_next = 4'd0;
            data_next = shreg;
            if (rx_s) begin
              valid_next = 1'b1;
              state_next = S_IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = S_WAIT;
            end
          end else begin
            tcnt_next = tcnt + 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are sent and a
// negedge monitor checks every valid / frame_err strobe against the queue.
module tb_uart_rx;

  localparam int BIT_CLK = 160;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [7:0] byte_val;
    bit         good;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   lat        = 0;
  bit   busy_prev  = 0;
  bit   valid_prev = 0;
  bit   ferr_prev  = 0;

  uart_rx #(.baudrate(10_000), .sysclk(1_600_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a frame yields its byte, good exactly when the stop bit is high.
  task automatic applyStimulus(input logic [7:0] b, input bit stop, input int bclk);
    exp_t e;
    e.byte_val = b;
    e.good     = stop;
    sb.push_back(e);
    drive(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive(b[i], bclk);
    drive(stop, bclk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy_prev  = 0;
      valid_prev = 0;
      ferr_prev  = 0;
      lat        = 0;
    end else begin
      if (busy && !busy_prev) lat = 0;
      else lat++;
      if (valid || frame_err) begin
        checkOutput("strobe_exclusive", int'(valid && frame_err), 0);
        checkOutput("strobe_width", int'((valid && valid_prev) || (frame_err && ferr_prev)), 0);
        checkOutput("strobe_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("data", int'(data), int'(e.byte_val));
          checkOutput("valid_vs_ferr", int'(valid), int'(e.good));
          checkRange("strobe_latency", lat, 1519, 1521);
        end
      end
      busy_prev  = busy;
      valid_prev = valid;
      ferr_prev  = frame_err;
    end
  end

  initial begin
    int rise, fall, waited, bclk, gap;
    logic [7:0] held, rb;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_ferr", int'(frame_err), 0);
    checkOutput("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 50);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, BIT_CLK);
    drive(1'b1, 200);
    checkOutput("single_busy_low", int'(busy), 0);
    checkOutput("single_data_held", int'(data), 8'hA5);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    applyStimulus(8'h00, 1'b1, BIT_CLK);
    applyStimulus(8'hFF, 1'b1, BIT_CLK);
    applyStimulus(8'h3C, 1'b1, BIT_CLK);
    drive(1'b1, 300);

    $display("[TB] 40-clock low glitch");
    held = data;
    rise = -1;
    fall = -1;
    rx   = 1'b0;
    for (int t = 0; t < 250; t++) begin
      if (t == 40) rx = 1'b1;
      @(negedge clk);
      if (busy && rise < 0) rise = t;
      if (!busy && rise >= 0 && fall < 0) fall = t;
    end
    checkOutput("glitch_busy_rose", int'(rise >= 0), 1);
    checkRange("glitch_busy_duration", fall - rise, 1, 90);
    checkOutput("glitch_data_unchanged", int'(data), int'(held));

    $display("[TB] framing error on 0x55");
    applyStimulus(8'h55, 1'b0, BIT_CLK);
    drive(1'b0, 3 * BIT_CLK);
    checkOutput("ferr_busy_while_low", int'(busy), 1);
    checkOutput("ferr_data_loaded", int'(data), 8'h55);
    drive(1'b1, 20);
    checkOutput("ferr_busy_released", int'(busy), 0);
    drive(1'b1, 2 * BIT_CLK);
    applyStimulus(8'h81, 1'b1, BIT_CLK);
    drive(1'b1, 300);

    $display("[TB] reset during data bit 4 of 0xC3");
    rb = 8'hC3;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(rb[i], BIT_CLK);
    drive(rb[4], BIT_CLK / 2);
    rst = 1'b1;
    #1;
    checkOutput("abort_data", int'(data), 0);
    checkOutput("abort_valid", int'(valid), 0);
    checkOutput("abort_ferr", int'(frame_err), 0);
    checkOutput("abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    drive(1'b1, 300);
    checkOutput("abort_no_pulse_data", int'(data), 0);
    applyStimulus(8'h12, 1'b1, BIT_CLK);
    drive(1'b1, 300);

    $display("[TB] 0x96 at +3%% and -3%% baud");
    applyStimulus(8'h96, 1'b1, 155);
    drive(1'b1, 300);
    applyStimulus(8'h96, 1'b1, 165);
    drive(1'b1, 300);

    $display("[TB] randomized frames");
    for (int n = 0; n < 8; n++) begin
      rb   = 8'($urandom_range(255));
      bclk = BIT_CLK - 4 + int'($urandom_range(8));
      gap  = int'($urandom_range(200));
      applyStimulus(rb, 1'b1, bclk);
      drive(1'b1, gap);
    end
    drive(1'b1, 200);
    checkOutput("last_data_held", int'(data), int'(rb));

    waited = 0;
    while (sb.size() > 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
